pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline stage register with valid/ready handshake, flush and optional skid slot.
//  Successor to the plain enable flop; used between CPU stages (IF/ID, ID/EX, ...) so stalls
//  propagate by back-pressure instead of shared enables. SKID=1 registers in_ready to cut the
//  combinational ready path between stages.
// PARAMETERS
//  WIDTH      32   payload width in bits
//  RESET_VAL  0    value loaded into every data register on rst or flush (WIDTH bits)
//  SKID       1    1: two-entry skid buffer, registered in_ready; 0: single entry, pass-through ready
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      asynchronous, active-high reset
//  flush      in   1      synchronous clear of all held entries (branch/exception kill)
//  in_valid   in   1      upstream offers in_data
//  in_ready   out  1      stage accepts in_data this cycle
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      out_data holds a valid entry
//  out_ready  in   1      downstream accepts out_data this cycle
//  out_data   out  WIDTH  payload of oldest held entry
//  count      out  2      number of held entries (0..1 if SKID=0, 0..2 if SKID=1)
// BEHAVIOUR
//  - Transfer in: in_valid&&in_ready at posedge. Transfer out: out_valid&&out_ready at posedge.
//  - Reset (async): out_valid=0, count=0, main and skid data = RESET_VAL; in_ready=1 after reset
//    deasserts (SKID=1: registered 1; SKID=0: follows equation below).
//  - Latency: accepted word appears on out_data the next cycle when stage was empty. Strict FIFO order.
//  - out_data/out_valid stable while out_valid && !out_ready (no drop, no change).
//  - Data registers update only on accept/shift; never on idle cycles.
//  - SKID=0: in_ready = !out_valid || out_ready (combinational). States EMPTY, FULL.
//  - SKID=1: states EMPTY(0), ONE(1), TWO(2); in_ready = (state != TWO), from a flop.
//    EMPTY: in -> ONE (main<=in).
//    ONE:   in&out -> ONE (main<=in); in only -> TWO (skid<=in); out only -> EMPTY.
//    TWO:   out -> ONE (main<=skid); no input accepted (in_ready=0).
//  - count mirrors state; out_valid = (count != 0).
//  - flush: next edge -> EMPTY, count=0, data regs = RESET_VAL, in_ready=1. Input offered in the
//    flush cycle is discarded; output transfer in the flush cycle still counts as consumed
//    downstream. flush has priority over all transfers; rst has priority over flush.
//  - rst mid-transfer: all held data lost, no partial state; handshake restarts from EMPTY.
//  - in_valid while in_ready=0: ignored, no state change; upstream must hold data.
// STRUCTURE
//  - Shared package/include pipe_defs: state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
//  - One sub-module: dffre_rv #(WIDTH,RESET_VAL) (clk,rst,clr,en,d,q) -- enable flop with
//    synchronous clear and parametric reset value; instantiated for main and skid data regs.
//  - Control FSM and ready flop in this module; SKID selected by generate.
// TESTING
//  1. rst=1 mid-run with count=2 -> out_valid=0, count=0, out_data=RESET_VAL immediately (async).
//  2. SKID=1, out_ready=1, stream 0x10,0x11,0x12 back-to-back -> same values out one cycle later,
//     in_ready held 1, count=1 throughout.
//  3. SKID=1, out_ready=0, send 0xA,0xB,0xC -> 0xA,0xB accepted, count=2, in_ready=0 on 3rd;
//     raise out_ready -> 0xA then 0xB then 0xC out in order, nothing lost or duplicated.
//  4. flush with count=2 and in_valid=1 (0x55) -> next cycle count=0, out_valid=0, 0x55 never output.
//  5. SKID=0, out_ready toggling 1,0,1 with continuous input -> in_ready equals !out_valid||out_ready
//     each cycle, out_data unchanged while stalled.
//  6. WIDTH=8, RESET_VAL=8'hFF: after rst and after flush out_data=0xFF; random valid/ready
//     scoreboard 10k cycles -> zero order/loss mismatches.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage definitions: occupancy state encodings used by the
// stage control FSM and exported on the count port.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/dffre_rv.sv
// Enable flop with synchronous clear and a parametric reset value; holds the
// payload for one pipeline slot.
module dffre_rv #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear beats enable so a flush always wins over a same-cycle load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and an optional
// skid slot that registers in_ready to break the upstream ready path.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  pipe_state_e      state_q;
  pipe_state_e      state_d;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and data-slot enables; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end else if (in_fire) begin
            // Only reachable with a skid slot: in_ready is 0 here otherwise.
            state_d = ST_TWO;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    count     = state_q;
    out_data  = main_q;
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  dffre_rv #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_main (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .en (main_en),
    .d  (main_d),
    .q  (main_q)
  );

  generate
    if (SKID) begin : g_skid
      logic in_ready_q;
      logic in_ready_d;

      // Ready is a registered copy of "next state has room".
      always_comb begin
        in_ready_d = (state_d != ST_TWO);
      end

      // Ready flop; comes out of reset accepting.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready = in_ready_q;

      dffre_rv #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
      ) u_skid (
        .clk(clk),
        .rst(rst),
        .clr(flush),
        .en (skid_en),
        .d  (in_data),
        .q  (skid_q)
      );
    end else begin : g_noskid
      assign in_ready = !out_valid || out_ready;
      assign skid_q   = RESET_VAL;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid-less and one skid instance, each with a
// queue scoreboard checking order, occupancy and ready behaviour every cycle.
module tb_pipe_stage_reg;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  RV = 8'hFF;

  logic       clk;
  logic       rst;
  logic       flush     [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_data   [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_data  [2];
  logic [1:0] count     [2];

  int         n_checks;
  int         n_pass;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       prev_stall[2];
  logic [7:0] prev_data [2];
  logic       last_fire [2];

  pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .count(count[0])
  );

  pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .count(count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int sb_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] sb_head(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic sb_push(input int d, input logic [7:0] v);
    if (d == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic sb_pop(input int d);
    if (d == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic sb_clear(input int d);
    if (d == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic eval_dut(input int d);
    int sz;
    logic exp_ready;
    sz = sb_size(d);
    exp_ready = (d == 1) ? (sz != 2) : (sz == 0 || out_ready[d]);
    check($sformatf("d%0d_count", d), 32'(count[d]), 32'(sz));
    check($sformatf("d%0d_out_valid", d), 32'(out_valid[d]), 32'(sz != 0));
    check($sformatf("d%0d_in_ready", d), 32'(in_ready[d]), 32'(exp_ready));
    if (sz != 0) check($sformatf("d%0d_out_data", d), 32'(out_data[d]), 32'(sb_head(d)));
    if (prev_stall[d]) check($sformatf("d%0d_stall_hold", d), 32'(out_data[d]), 32'(prev_data[d]));
    prev_stall[d] = out_valid[d] && !out_ready[d] && !flush[d];
    prev_data[d]  = out_data[d];
    last_fire[d]  = in_valid[d] && in_ready[d] && !flush[d];
    if (out_valid[d] && out_ready[d] && sz != 0) sb_pop(d);
    if (in_valid[d] && in_ready[d]) sb_push(d, in_data[d]);
    if (flush[d]) sb_clear(d);
  endtask

  // One clock: settle, score both DUTs, advance to just after the edge.
  task automatic cycle();
    #2;
    eval_dut(0);
    eval_dut(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      flush[d]     = 1'b0;
      in_valid[d]  = 1'b0;
      in_data[d]   = 8'h00;
      out_ready[d] = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    idle_all();
    for (int d = 0; d < 2; d++) begin
      prev_stall[d] = 1'b0;
      prev_data[d]  = 8'h00;
      last_fire[d]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_data", d), 32'(out_data[d]), 32'(RV));
      check($sformatf("d%0d_rst_ready", d), 32'(in_ready[d]), 32'd1);
      check($sformatf("d%0d_rst_count", d), 32'(count[d]), 32'd0);
    end
    cycle();

    // Back-to-back stream through the skid stage.
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[1] = 8'h10 + 8'(i);
      cycle();
    end
    in_valid[1] = 1'b0;
    cycle();
    cycle();

    // Back-pressure: A,B fill the stage, C waits until drain starts.
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = 8'h0A;
    cycle();
    in_data[1] = 8'h0B;
    cycle();
    in_data[1] = 8'h0C;
    cycle();
    check("bp_full_ready", 32'(in_ready[1]), 32'd0);
    out_ready[1] = 1'b1;
    for (int i = 0; i < 6 && in_valid[1]; i++) begin
      cycle();
      if (last_fire[1] && in_data[1] == 8'h0C) in_valid[1] = 1'b0;
    end
    check("bp_c_accepted", 32'(in_valid[1]), 32'd0);
    repeat (3) cycle();

    // Flush with two held entries and an offered word that must vanish.
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = 8'h21;
    cycle();
    in_data[1] = 8'h22;
    cycle();
    flush[1]   = 1'b1;
    in_data[1] = 8'h55;
    cycle();
    flush[1]    = 1'b0;
    in_valid[1] = 1'b0;
    #2;
    check("flush_data", 32'(out_data[1]), 32'(RV));
    check("flush_count", 32'(count[1]), 32'd0);
    check("flush_ready", 32'(in_ready[1]), 32'd1);
    out_ready[1] = 1'b1;
    repeat (3) cycle();

    // Skid-less stage, continuous input, out_ready 1,0,1,0,1,1.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h30;
    for (int i = 0; i < 6; i++) begin
      out_ready[0] = (i == 1 || i == 3) ? 1'b0 : 1'b1;
      cycle();
      if (last_fire[0]) in_data[0] = in_data[0] + 8'd1;
    end
    in_valid[0] = 1'b0;
    repeat (2) cycle();

    // Async reset with the skid stage full.
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = 8'h41;
    cycle();
    in_data[1] = 8'h42;
    cycle();
    check("pre_rst_count", 32'(count[1]), 32'd2);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid[1]), 32'd0);
    check("arst_count", 32'(count[1]), 32'd0);
    check("arst_data", 32'(out_data[1]), 32'(RV));
    idle_all();
    sb_clear(0);
    sb_clear(1);
    for (int d = 0; d < 2; d++) prev_stall[d] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // Random traffic with occasional flushes on both stages.
    for (int n = 0; n < 10000; n++) begin
      for (int d = 0; d < 2; d++) begin
        flush[d]     = ($urandom_range(0, 199) == 0);
        in_valid[d]  = $urandom_range(0, 1) == 1;
        in_data[d]   = 8'($urandom);
        out_ready[d] = $urandom_range(0, 2) != 0;
      end
      cycle();
    end
    idle_all();
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    repeat (4) cycle();
    check("d0_drained", 32'(sb_size(0)), 32'd0);
    check("d1_drained", 32'(sb_size(1)), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
